// File: rtl/frame_composer_pkg.sv
// Shared types, geometry constants and row helpers for the 16x16 frame composer.
package frame_composer_pkg;

  localparam int unsigned COLS   = 16;
  localparam int unsigned ROWS   = 16;
  localparam int unsigned DBITS  = 2;
  localparam int unsigned ROW_W  = COLS * DBITS;
  localparam int unsigned ROW_AW = 4;

  typedef enum logic [1:0] {
    OpPixel = 2'b00,
    OpFill  = 2'b01,
    OpSwap  = 2'b10,
    OpNop   = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StSwapWait,
    StCopy
  } state_e;

  // Bit-mask selecting the density field of column x within a row word.
  function automatic logic [ROW_W-1:0] pixel_mask(input logic [ROW_AW-1:0] x);
    logic [ROW_W-1:0] m;
    m = '0;
    m[DBITS*x +: DBITS] = '1;
    return m;
  endfunction

  function automatic logic [ROW_W-1:0] fill_row(input logic [DBITS-1:0] d);
    return {COLS{d}};
  endfunction

endpackage

// File: rtl/fb_bank_16x16.sv
// One 16-row bitmap bank: masked row write, async clear, two combinational read ports.
module fb_bank_16x16
  import frame_composer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ROW_AW-1:0] waddr,
  input  logic [ROW_W-1:0]  wdata,
  input  logic [ROW_W-1:0]  wmask,
  input  logic [ROW_AW-1:0] raddr_a,
  output logic [ROW_W-1:0]  rdata_a,
  input  logic [ROW_AW-1:0] raddr_b,
  output logic [ROW_W-1:0]  rdata_b
);

  logic [ROW_W-1:0] mem_q [ROWS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ROWS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= (mem_q[waddr] & ~wmask) | (wdata & wmask);
    end
  end

  // Port a serves the display scan, port b the bank-to-bank copy.
  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/frame_composer_16x16.sv
// Command-driven composer for a double-buffered 16x16 2-bit bitmap; swaps on frame boundary.
module frame_composer_16x16
  import frame_composer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ROW_AW-1:0] cmd_x,
  input  logic [ROW_AW-1:0] cmd_y,
  input  logic [DBITS-1:0]  cmd_density,
  input  logic              frame_start,
  input  logic [ROW_AW-1:0] rd_row,
  output logic [ROW_W-1:0]  rd_data,
  output logic              front_sel,
  output logic              busy
);

  state_e             state_q, state_d;
  logic [ROW_AW-1:0]  row_q, row_d;
  logic [DBITS-1:0]   dens_q, dens_d;
  logic               front_q, front_d;
  logic [ROW_W-1:0]   rd_data_q;

  cmd_op_e            op;
  logic               accept;
  logic               last_row;

  logic               wr_en;
  logic [ROW_AW-1:0]  wr_row;
  logic [ROW_W-1:0]   wr_data;
  logic [ROW_W-1:0]   wr_mask;
  logic [1:0]         bank_we;

  logic [ROW_W-1:0]   scan_rd0, scan_rd1, copy_rd0, copy_rd1;
  logic [ROW_W-1:0]   front_row, copy_src;

  assign op       = cmd_op_e'(cmd_op);
  assign accept   = cmd_valid && cmd_ready;
  assign last_row = (row_q == ROW_AW'(ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      dens_q  <= '0;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dens_q  <= dens_d;
      front_q <= front_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dens_d  = dens_q;
    front_d = front_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpFill: begin
              dens_d  = cmd_density;
              row_d   = '0;
              state_d = StFill;
            end
            OpSwap:  state_d = StSwapWait;
            default: ;
          endcase
        end
      end
      StFill: begin
        row_d = row_q + 1'b1;
        if (last_row) state_d = StIdle;
      end
      // Only reachable the cycle after acceptance, so a coincident pulse is ignored.
      StSwapWait: begin
        if (frame_start) begin
          front_d = ~front_q;
          row_d   = '0;
          state_d = StCopy;
        end
      end
      StCopy: begin
        row_d = row_q + 1'b1;
        if (last_row) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_en     = 1'b0;
    wr_row    = row_q;
    wr_data   = '0;
    wr_mask   = '0;
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    unique case (state_q)
      StIdle: begin
        if (accept && op == OpPixel) begin
          wr_en   = 1'b1;
          wr_row  = cmd_y;
          wr_mask = pixel_mask(cmd_x);
          wr_data = fill_row(cmd_density);
        end
      end
      StFill: begin
        wr_en   = 1'b1;
        wr_mask = '1;
        wr_data = fill_row(dens_q);
      end
      StCopy: begin
        wr_en   = 1'b1;
        wr_mask = '1;
        wr_data = copy_src;
      end
      default: ;
    endcase
  end

  // Writes always land in the back bank.
  assign bank_we[0] = wr_en &  front_q;
  assign bank_we[1] = wr_en & ~front_q;

  fb_bank_16x16 u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (bank_we[0]),
    .waddr   (wr_row),
    .wdata   (wr_data),
    .wmask   (wr_mask),
    .raddr_a (rd_row),
    .rdata_a (scan_rd0),
    .raddr_b (row_q),
    .rdata_b (copy_rd0)
  );

  fb_bank_16x16 u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (bank_we[1]),
    .waddr   (wr_row),
    .wdata   (wr_data),
    .wmask   (wr_mask),
    .raddr_a (rd_row),
    .rdata_a (scan_rd1),
    .raddr_b (row_q),
    .rdata_b (copy_rd1)
  );

  assign front_row = front_q ? scan_rd1 : scan_rd0;
  assign copy_src  = front_q ? copy_rd1 : copy_rd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= front_row;
    end
  end

  assign rd_data   = rd_data_q;
  assign front_sel = front_q;

endmodule

// File: tb/tb_frame_composer_16x16.sv
// Directed bench for frame_composer_16x16 with a queue of expected read-port words.
module tb_frame_composer_16x16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b11;
  logic [3:0]  cmd_x = '0;
  logic [3:0]  cmd_y = '0;
  logic [1:0]  cmd_density = '0;
  logic        frame_start = 1'b0;
  logic [3:0]  rd_row = '0;
  logic [31:0] rd_data;
  logic        front_sel;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q [$];

  localparam logic [1:0] PIXEL = 2'b00;
  localparam logic [1:0] FILL  = 2'b01;
  localparam logic [1:0] SWAP  = 2'b10;

  frame_composer_16x16 dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_density (cmd_density),
    .frame_start (frame_start),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .front_sel   (front_sel),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                      input logic [1:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_x = x;
    cmd_y = y;
    cmd_density = d;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("send_ready", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'b11;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic read_row(input logic [3:0] r, input logic [31:0] exp);
    rd_row = r;
    exp_q.push_back(exp);
    tick();
    check($sformatf("row%0d", r), rd_data, exp_q.pop_front());
  endtask

  initial begin
    int n;
    // Reset state and blank banks.
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_front_sel", 32'(front_sel), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    for (int r = 0; r < 16; r++) read_row(4'(r), 32'h0);

    // Single pixel then swap.
    send(PIXEL, 4'd3, 4'd5, 2'd2);
    send(SWAP, 4'd0, 4'd0, 2'd0);
    check("swap_wait_busy", 32'(busy), 32'd1);
    check("swap_wait_front", 32'(front_sel), 32'd0);
    pulse_fs();
    check("swap1_front", 32'(front_sel), 32'd1);
    for (int r = 0; r < 16; r++) read_row(4'(r), (r == 5) ? 32'h0000_0080 : 32'h0);
    wait_idle();

    // Fill takes exactly 16 busy cycles.
    send(FILL, 4'd0, 4'd0, 2'd3);
    check("fill_ready_low", 32'(cmd_ready), 32'd0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
    check("fill_busy_cycles", 32'(n), 32'd16);
    send(SWAP, 4'd0, 4'd0, 2'd0);
    pulse_fs();
    check("swap2_front", 32'(front_sel), 32'd0);
    for (int r = 0; r < 16; r++) read_row(4'(r), 32'hFFFF_FFFF);
    wait_idle();

    // Incremental draw on top of the copied frame.
    send(PIXEL, 4'd0, 4'd0, 2'd0);
    send(SWAP, 4'd0, 4'd0, 2'd0);
    pulse_fs();
    check("swap3_front", 32'(front_sel), 32'd1);
    for (int r = 0; r < 16; r++) read_row(4'(r), (r == 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
    wait_idle();

    // SWAP accepted together with frame_start: that pulse must not toggle.
    send(PIXEL, 4'd15, 4'd15, 2'd1);
    cmd_valid = 1'b1;
    cmd_op = SWAP;
    frame_start = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'b11;
    frame_start = 1'b0;
    check("coincident_front", 32'(front_sel), 32'd1);
    check("coincident_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check("waiting_front", 32'(front_sel), 32'd1);
    rd_row = 4'd15;
    frame_start = 1'b1;
    exp_q.push_back(32'hFFFF_FFFF);
    tick();
    frame_start = 1'b0;
    check("toggle_cycle_old_bank", rd_data, exp_q.pop_front());
    check("toggle_front", 32'(front_sel), 32'd0);
    read_row(4'd15, 32'h7FFF_FFFF);

    // Command held during COPY waits for the first IDLE cycle.
    cmd_valid = 1'b1;
    cmd_op = PIXEL;
    cmd_x = 4'd1;
    cmd_y = 4'd2;
    cmd_density = 2'd0;
    check("copy_ready_low", 32'(cmd_ready), 32'd0);
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check("held_wait_cycles", 32'(n), 32'd15);
    tick();
    cmd_valid = 1'b0;
    cmd_op = 2'b11;
    check("held_accepted_idle", 32'(busy), 32'd0);
    send(SWAP, 4'd0, 4'd0, 2'd0);
    pulse_fs();
    check("swap5_front", 32'(front_sel), 32'd1);
    read_row(4'd2, 32'hFFFF_FFF3);
    read_row(4'd0, 32'hFFFF_FFFC);

    // Asynchronous reset while copying row 7.
    for (int i = 0; i < 5; i++) tick();
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_front", 32'(front_sel), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rd_data", rd_data, 32'h0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'd1);
    for (int r = 0; r < 16; r++) read_row(4'(r), 32'h0);
    send(SWAP, 4'd0, 4'd0, 2'd0);
    pulse_fs();
    check("post_rst_front", 32'(front_sel), 32'd1);
    read_row(4'd0, 32'h0);
    read_row(4'd2, 32'h0);
    read_row(4'd15, 32'h0);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
